// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-NUM_OUT stream demultiplexer.
//
// Each accepted input word is steered to the output channel picked by in_sel.
// Every channel has a one-entry holding register with a valid/ready handshake.
// Words whose select is out of range are accepted, dropped and counted.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    input word present
//   in_ready    block can take the input word this cycle (combinational)
//   in_data     input word
//   in_sel      destination channel index, sampled with in_data
//   out_valid   per-channel word present
//   out_ready   per-channel consumer accept
//   out_data    flattened channel data, channel k at [k*DATA_W +: DATA_W]
//   drop_pulse  one-cycle pulse after an out-of-range word is dropped
//   drop_cnt    saturating count of dropped words
module stream_demux_n #(
  parameter int unsigned NUM_OUT = 8,
  parameter int unsigned DATA_W  = 8,
  localparam int unsigned SEL_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [SEL_W-1:0]            in_sel,
  output logic [NUM_OUT-1:0]          out_valid,
  input  logic [NUM_OUT-1:0]          out_ready,
  output logic [NUM_OUT*DATA_W-1:0]   out_data,
  output logic                        drop_pulse,
  output logic [15:0]                 drop_cnt
);

  logic [NUM_OUT-1:0] valid_q;
  logic [NUM_OUT-1:0] valid_d;
  logic [DATA_W-1:0]  data_q [NUM_OUT];
  logic               drop_pulse_q;
  logic [15:0]        drop_cnt_q;

  logic [NUM_OUT-1:0] sel_oh;
  logic               in_range;
  logic               in_xfer;
  logic [NUM_OUT-1:0] load;

  // Select decode. An out-of-range select yields an all-zero one-hot vector,
  // which doubles as the drop indication.
  always_comb begin
    sel_oh = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if ({1'b0, in_sel} == k[SEL_W:0]) begin
        sel_oh[k] = 1'b1;
      end
    end
  end

  assign in_range = |sel_oh;

  // A full channel that drains this cycle still accepts, giving one word per
  // cycle per channel. Dropped words are always accepted.
  assign in_ready = ~rst & (~in_range | (|(sel_oh & (~valid_q | out_ready))));

  assign in_xfer  = in_valid & in_ready;
  assign load     = in_xfer ? sel_oh : '0;

  // Load wins over drain so a simultaneous in/out transfer keeps the channel full.
  assign valid_d  = (valid_q & ~(valid_q & out_ready)) | load;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      drop_pulse_q <= in_xfer & ~in_range;
      if (in_xfer && !in_range && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (load[k]) begin
          data_q[k] <= in_data;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      out_data[k*DATA_W +: DATA_W] = data_q[k];
    end
  end

  assign out_valid  = valid_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_n.sv
module tb_stream_demux_n;

  logic        clk = 1'b0;
  logic        rst;

  // 8-channel instance
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [63:0] out_data;
  logic        drop_pulse;
  logic [15:0] drop_cnt;

  // 6-channel instance (reaches the drop path)
  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_in_data;
  logic [2:0]  b_in_sel;
  logic [5:0]  b_out_valid;
  logic [5:0]  b_out_ready;
  logic [47:0] b_out_data;
  logic        b_drop_pulse;
  logic [15:0] b_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_demux_n #(.NUM_OUT(8), .DATA_W(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  stream_demux_n #(.NUM_OUT(6), .DATA_W(8)) u_dut6 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_data    (b_in_data),
    .in_sel     (b_in_sel),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_data   (b_out_data),
    .drop_pulse (b_drop_pulse),
    .drop_cnt   (b_drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    in_sel      = 3'd0;
    out_ready   = 8'hFF;
    b_in_valid  = 1'b0;
    b_in_data   = 8'h00;
    b_in_sel    = 3'd0;
    b_out_ready = 6'h3F;
    tick();
    tick();

    // Outputs during reset
    chk("rst_in_ready",  64'(in_ready),   64'h0);
    chk("rst_out_valid", 64'(out_valid),  64'h0);
    chk("rst_out_data",  out_data,        64'h0);
    chk("rst_drop_pulse",64'(drop_pulse), 64'h0);
    chk("rst_drop_cnt",  64'(drop_cnt),   64'h0);
    chk("rst_b_valid",   64'(b_out_valid),64'h0);

    // 1. Route A5 to channel 3
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'hA5; in_sel = 3'd3;
    #1;
    chk("t1_in_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'h08);
    chk("t1_data3", 64'(out_data[31:24]), 64'hA5);
    tick();
    chk("t1_drained", 64'(out_valid), 64'h00);

    // 2. Back-pressure on channel 5
    out_ready = 8'hDF;
    in_valid = 1'b1; in_data = 8'h11; in_sel = 3'd5;
    #1;
    chk("t2_first_ready", 64'(in_ready), 64'h1);
    tick();
    in_data = 8'h22;
    #1;
    chk("t2_second_blocked", 64'(in_ready), 64'h0);
    chk("t2_valid", 64'(out_valid), 64'h20);
    chk("t2_data5", 64'(out_data[47:40]), 64'h11);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_stall_valid", 64'(out_valid), 64'h20);
      chk("t2_stall_data",  64'(out_data[47:40]), 64'h11);
      chk("t2_stall_ready", 64'(in_ready), 64'h0);
    end
    out_ready = 8'hFF;
    #1;
    chk("t2_release_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    chk("t2_second_valid", 64'(out_valid), 64'h20);
    chk("t2_second_data",  64'(out_data[47:40]), 64'h22);
    tick();
    chk("t2_drained", 64'(out_valid), 64'h00);

    // 3. Full throughput on channel 0
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_sel = 3'd0;
      #1;
      chk("t3_ready", 64'(in_ready), 64'h1);
      tick();
      chk("t3_valid", 64'(out_valid), 64'h01);
      chk("t3_data0", 64'(out_data[7:0]), 64'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("t3_drained", 64'(out_valid), 64'h00);

    // 4. Stalled channel 2 does not block channel 6
    out_ready = 8'hFB;
    in_valid = 1'b1; in_data = 8'h33; in_sel = 3'd2;
    tick();
    in_data = 8'h44; in_sel = 3'd6;
    #1;
    chk("t4_ready6", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    chk("t4_valid", 64'(out_valid), 64'h44);
    chk("t4_data6", 64'(out_data[55:48]), 64'h44);
    chk("t4_data2", 64'(out_data[23:16]), 64'h33);
    tick();
    chk("t4_ch6_drained", 64'(out_valid), 64'h04);
    chk("t4_data2_hold", 64'(out_data[23:16]), 64'h33);
    out_ready = 8'hFF;
    tick();
    chk("t4_all_drained", 64'(out_valid), 64'h00);

    // X on select while idle must not disturb state
    in_sel = 3'bxxx;
    tick();
    tick();
    chk("x_valid", 64'(out_valid), 64'h00);
    chk("x_drop_cnt", 64'(drop_cnt), 64'h0);
    in_sel = 3'd0;

    // 5. Out-of-range drops on the 6-channel instance (sel 6 is the first invalid)
    b_in_valid = 1'b1; b_in_data = 8'h5A; b_in_sel = 3'd5;
    tick();
    chk("t5_ch5_valid", 64'(b_out_valid), 64'h20);
    chk("t5_ch5_data", 64'(b_out_data[47:40]), 64'h5A);
    chk("t5_ch5_no_drop", 64'(b_drop_pulse), 64'h0);
    b_in_sel = 3'd7;
    #1;
    chk("t5_ready_a", 64'(b_in_ready), 64'h1);
    tick();
    chk("t5_pulse_a", 64'(b_drop_pulse), 64'h1);
    chk("t5_cnt_a", 64'(b_drop_cnt), 64'h1);
    b_in_sel = 3'd6;
    #1;
    chk("t5_ready_b", 64'(b_in_ready), 64'h1);
    tick();
    chk("t5_pulse_b", 64'(b_drop_pulse), 64'h1);
    chk("t5_cnt_b", 64'(b_drop_cnt), 64'h2);
    b_in_sel = 3'd7;
    #1;
    chk("t5_ready_c", 64'(b_in_ready), 64'h1);
    tick();
    b_in_valid = 1'b0;
    chk("t5_pulse_c", 64'(b_drop_pulse), 64'h1);
    chk("t5_cnt_c", 64'(b_drop_cnt), 64'h3);
    chk("t5_no_valid", 64'(b_out_valid), 64'h00);
    tick();
    chk("t5_pulse_off", 64'(b_drop_pulse), 64'h0);
    chk("t5_cnt_hold", 64'(b_drop_cnt), 64'h3);

    // Saturation: 65532 more drops reach FFFF, further drops stick
    b_in_valid = 1'b1; b_in_sel = 3'd7;
    repeat (65532) @(posedge clk);
    #1;
    chk("t5_cnt_max", 64'(b_drop_cnt), 64'hFFFF);
    repeat (4) tick();
    chk("t5_cnt_sat", 64'(b_drop_cnt), 64'hFFFF);
    chk("t5_pulse_sat", 64'(b_drop_pulse), 64'h1);
    b_in_valid = 1'b0;
    tick();

    // 6. Reset mid-operation
    out_ready = 8'h00;
    in_valid = 1'b1; in_data = 8'h61; in_sel = 3'd1;
    tick();
    in_data = 8'h64; in_sel = 3'd4;
    tick();
    in_valid = 1'b0;
    chk("t6_held", 64'(out_valid), 64'h12);
    rst = 1'b1;
    in_valid = 1'b1; in_data = 8'h77; in_sel = 3'd1;
    #1;
    chk("t6_rst_ready", 64'(in_ready), 64'h0);
    tick();
    rst = 1'b0;
    chk("t6_valid_clr", 64'(out_valid), 64'h00);
    chk("t6_data_clr", out_data, 64'h0);
    chk("t6_cnt_clr", 64'(drop_cnt), 64'h0);
    chk("t6_b_cnt_clr", 64'(b_drop_cnt), 64'h0);
    #1;
    chk("t6_post_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    chk("t6_post_valid", 64'(out_valid), 64'h02);
    chk("t6_post_data1", 64'(out_data[15:8]), 64'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Parametrised, registered 1-to-NUM_OUT stream demultiplexer.
- Successor to the combinational 1:8 demux tree.
- Routes each accepted input word to the output channel picked by in_sel, through a per-channel one-entry holding register with valid/ready handshake.
- Out-of-range selects are dropped and counted. Used wherever one producer feeds several back-pressuring consumers.

Parameters:
- NUM_OUT, 8, number of output channels (2..16).
- DATA_W, 8, data word width in bits (1..64).
- SEL_W (localparam), max(1, clog2(NUM_OUT)), select width. Derived; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the input word this cycle
- in_data  input  DATA_W  input word
- in_sel  input  SEL_W  destination channel index, sampled with in_data
- out_valid  output  NUM_OUT  per-channel word present
- out_ready  input  NUM_OUT  per-channel consumer accept
- out_data  output  NUM_OUT*DATA_W  flattened; channel k occupies bits [k*DATA_W +: DATA_W]
- drop_pulse  output  1  one-cycle pulse when a word is dropped for an out-of-range select
- drop_cnt  output  16  saturating count of dropped words

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid = 0, out_data = 0, drop_pulse = 0, drop_cnt = 0.
  - Held words are discarded, including when reset hits mid-stream.
  - in_ready is driven 0 while rst is high.
- Handshake:
  - An input transfer happens when in_valid & in_ready at a clk edge.
  - An output transfer on channel k happens when out_valid[k] & out_ready[k] at a clk edge.
- in_ready (combinational from in_sel, out_valid, out_ready; no path from in_data):
  - If in_sel >= NUM_OUT: in_ready = 1. The word is accepted and dropped.
  - Otherwise: in_ready = ~out_valid[in_sel] | out_ready[in_sel], so a full-but-draining register accepts in the same cycle (full throughput).
- Channel k register update, per clk edge:
  - Input transfer to k, with or without a simultaneous output transfer on k: load in_data, out_valid[k] = 1.
  - Output transfer on k only: out_valid[k] = 0. out_data[k] keeps its last value (don't-care once invalid).
  - Otherwise: hold.
- Latency: an accepted word appears on out_data[k] with out_valid[k] = 1 exactly one cycle after acceptance.
- Stability: while out_valid[k] & ~out_ready[k], out_data[k] must not change.
- Channel independence: a channel not selected by the input still drains on its own out_ready. A stalled channel k blocks only inputs addressed to k; there is no head-of-line effect on other channels beyond the single shared input port.
- Ordering: words to the same channel leave in acceptance order. No ordering guarantee across channels.
- Drop path: an accepted out-of-range word asserts drop_pulse for exactly the next cycle and increments drop_cnt by 1. drop_cnt saturates at 16'hFFFF and clears only on reset. This path is only reachable when NUM_OUT is not a power of two.
- in_valid = 0: in_ready is still computed and meaningful. No state changes except output drains.
- X on in_sel while in_valid = 0 must not corrupt state.

Test Plan:
1. Reset then route (NUM_OUT=8, DATA_W=8). Single word 8'hA5 with sel=3 and out_ready all 1 -> next cycle out_valid = 8'b0000_1000, channel 3 data = A5. One cycle later out_valid = 0. All outputs are 0 during reset.
2. Back-pressure. out_ready[5] = 0; send 8'h11 then 8'h22 with sel=5 on consecutive cycles -> first accepted, in_ready = 0 for the second. Channel 5 holds 11 stable for 4 stall cycles. Raise out_ready[5] -> 22 accepted that same edge and appears the next cycle.
3. Full throughput on one channel. out_ready[0] = 1; stream 8'h00..8'h0F with sel=0 every cycle -> in_ready constantly 1. Channel 0 shows 00..0F one per cycle, 1-cycle lag, no gaps.
4. Independent drain. Channel 2 stalled holding 8'h33; send 8'h44 with sel=6 -> accepted immediately. Channel 6 valid next cycle while channel 2 still holds 33.
5. Out-of-range drop (NUM_OUT=6, SEL_W=3). Send 3 words with sel=7 -> in_ready = 1 each. drop_pulse is high one cycle after each. drop_cnt = 3. out_valid stays 0. Also preload drop_cnt near saturation via a long stream and check it sticks at FFFF.
6. Reset mid-operation. Channels 1 and 4 holding with out_ready = 0; assert rst for 1 cycle -> out_valid = 0 and drop_cnt = 0 after the edge. A new word with sel=1 is accepted the cycle after rst deasserts.
